xadc_drp_scheduler: RTL
=======================

Name: xadc_drp_scheduler

Overview:
Sequences XADC DRP accesses across a programmable list of auxiliary-channel slots and shares the single DRP port with a host (AXI-side) register access path.
- Issues one slot read per XADC end-of-conversion, round-robin over enabled slots, and keeps the latest 16-bit result per slot.
- Arbitrates host DRP read/write requests against scan reads with alternating priority.
- Sits between xadc_wiz_0's DRP port and the AXI slave register logic.

Parameters:
NUM_SLOTS, 4, number of scan slots (2..8); slot index width SW = clog2(NUM_SLOTS)
TIMEOUT, 63, cycles allowed from den to drdy before a transaction is abandoned

Ports:
S_AXI_ACLK  in  1  clock (also DRP dclk)
S_AXI_ARESET  in  1  synchronous active-high reset
enable  in  1  scan enable; eoc ignored when low
slot_mask  in  NUM_SLOTS  bit i=1 includes slot i in the scan
slot_addr_cfg  in  7*NUM_SLOTS  DRP address of slot i at bits [7i+6:7i]
eoc  in  1  XADC end-of-conversion pulse
den  out  1  DRP enable, one-cycle pulse
dwe  out  1  DRP write enable, valid with den
daddr  out  7  DRP address, valid with den
di  out  16  DRP write data, valid with den
drdy  in  1  DRP data ready
do_in  in  16  DRP read data, valid with drdy
host_req  in  1  host access request; level, held until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  7  host DRP address
host_wdata  in  16  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  16  read data, valid with host_ack
slot_data  out  16*NUM_SLOTS  latest result of each slot
sample_valid  out  1  one-cycle pulse when a slot result updates
sample_slot  out  SW  slot index updated, valid with sample_valid
timeout_err  out  1  sticky: a DRP transaction timed out
overrun_err  out  1  sticky: eoc arrived while a scan read was already pending
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset values: all outputs 0; slot pointer 0; scan_pending 0; last_grant = host; FSM in IDLE. Reset mid-transaction abandons it: no ack, no sample_valid.
- scan_pending: set when eoc && enable. If it is already set, or a scan read is in flight, set overrun_err instead (pending stays set). Cleared when a scan transaction completes or times out.
- Scan read pick: starting at the slot pointer, the first enabled slot in wrap order.
  - slot_mask == 0 while pending: clear pending silently; no DRP access.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, host_req and scan_pending both set: grant the side opposite last_grant.
  - IDLE, only one set: grant that side.
  - Grant moves to ISSUE and records owner and last_grant.
  - ISSUE: den=1 for exactly one cycle, with daddr/dwe/di.
    - Scan: daddr = slot address, dwe=0, di=0.
    - Host: host_addr, host_we, host_wdata.
    - Then WAIT; timeout counter cleared.
  - WAIT, drdy: go to IDLE.
    - Scan: slot_data[slot] <= do_in; next cycle sample_valid=1 and sample_slot=slot; pointer <= picked slot + 1 (wrap to 0).
    - Host: host_rdata <= do_in (also for writes); next cycle host_ack=1.
  - WAIT, counter reaches TIMEOUT: set timeout_err, go to IDLE.
    - Scan: pointer advances; slot_data unchanged; no sample_valid.
    - Host: host_ack pulses with host_rdata=0.
- Latency: eoc sampled at edge N with FSM idle and no host request -> den high in cycle N+2. drdy sampled at edge M -> sample_valid/host_ack high in cycle M+1.
- Host request dropped before ack: transaction still completes and host_ack still pulses. Host owns the port until ack.
- drdy outside WAIT: ignored.
- enable deasserted mid-transaction: the transaction completes; already-pending scan still serviced.
- err_clr and a new error in the same cycle: the error wins (flag stays set).
- slot_mask and slot_addr_cfg are sampled at grant; changes during WAIT do not affect the in-flight access.

Decomposition:
- Package xadc_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT};
  - owner enum {OWN_SCAN, OWN_HOST};
  - DRP constants: DRP_AW=7, DRP_DW=16;
  - VAUX channel addresses VAUX6=7'h16, VAUX7=7'h17, VAUX14=7'h1E, VAUX15=7'h1F.
- One sub-module: xadc_rr_slot_pick, the combinational next-enabled-slot finder (mask, pointer -> slot, found). It is reusable by the AXI register block.

Test Plan:
- mask=4'b1111, addrs {16,1F,17,1E}, 4 eoc pulses with drdy 3 cycles after den.
  - daddr sequence 1E,17,1F,16.
  - sample_slot 0,1,2,3; slot_data updated with driven values.
  - den at eoc+2.
- mask=4'b1010, 4 eoc pulses -> only slots 1,3,1,3 read; slots 0,2 stay 0.
- host read (addr 7'h00) asserted in the same cycle as pending scan, last_grant=host.
  - Scan goes first, then host.
  - host_ack with host_rdata equal to the driven do_in.
  - A repeat with last_grant=scan serves host first.
- drdy never returned for a scan read.
  - After 63 cycles: timeout_err=1, no sample_valid, pointer advances.
  - err_clr clears it.
- second eoc during WAIT -> overrun_err=1; only one read is issued for both pulses.
- reset asserted in WAIT.
  - den/host_ack/sample_valid stay 0; all slot_data 0.
  - Next eoc reads slot 0.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP scan/host scheduler.
// Also used by the AXI register block for VAUX channel addressing.
package xadc_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    localparam logic [DRP_AW-1:0] VAUX6  = 7'h16;
    localparam logic [DRP_AW-1:0] VAUX7  = 7'h17;
    localparam logic [DRP_AW-1:0] VAUX14 = 7'h1E;
    localparam logic [DRP_AW-1:0] VAUX15 = 7'h1F;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_SCAN, OWN_HOST} owner_t;

endpackage

// File: rtl/xadc_rr_slot_pick.sv
// Combinational round-robin finder: first set mask bit at or after ptr, in wrap order.
// Zero latency; no handshake.
module xadc_rr_slot_pick #(
    parameter int NUM_SLOTS = 4,
    parameter int SW        = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] mask,
    input  logic [SW-1:0]        ptr,
    output logic [SW-1:0]        slot,
    output logic                 found
);

    always_comb begin
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        slot  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        // Walk from the farthest candidate back to ptr so the nearest hit wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (SW+1)'(i);
            if (sum >= (SW+1)'(NUM_SLOTS)) begin
                sum = sum - (SW+1)'(NUM_SLOTS);
            end
            idx = sum[SW-1:0];
            if (mask[idx]) begin
                slot  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// Shares one XADC DRP port between round-robin slot scan reads (one per eoc) and host accesses.
// den two cycles after eoc when idle; results/ack one cycle after drdy; host holds req until ack.
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 63,
    localparam int SW       = $clog2(NUM_SLOTS)
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    input  logic                        enable,
    input  logic [NUM_SLOTS-1:0]        slot_mask,
    input  logic [DRP_AW*NUM_SLOTS-1:0] slot_addr_cfg,
    input  logic                        eoc,
    output logic                        den,
    output logic                        dwe,
    output logic [DRP_AW-1:0]           daddr,
    output logic [DRP_DW-1:0]           di,
    input  logic                        drdy,
    input  logic [DRP_DW-1:0]           do_in,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [DRP_AW-1:0]           host_addr,
    input  logic [DRP_DW-1:0]           host_wdata,
    output logic                        host_ack,
    output logic [DRP_DW-1:0]           host_rdata,
    output logic [DRP_DW*NUM_SLOTS-1:0] slot_data,
    output logic                        sample_valid,
    output logic [SW-1:0]               sample_slot,
    output logic                        timeout_err,
    output logic                        overrun_err,
    input  logic                        err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    owner_t            owner, last_grant;
    logic [SW-1:0]     ptr, cur_slot, pick_slot;
    logic              pick_found;
    logic [DRP_AW-1:0] cur_addr;
    logic [CW-1:0]     cnt;
    logic              scan_pending;
    logic              scan_want, host_want, scan_req, scan_end;
    logic              grant_scan, grant_host, done, expired;

    xadc_rr_slot_pick #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_pick (
        .mask  (slot_mask),
        .ptr   (ptr),
        .slot  (pick_slot),
        .found (pick_found)
    );

    assign scan_req  = eoc && enable;
    assign scan_want = scan_pending && pick_found;
    // The ack cycle is masked so a request level still high from the finished access is not re-granted.
    assign host_want = host_req && !host_ack;
    assign scan_end  = (done || expired) && (owner == OWN_SCAN);

    always_comb begin
        state_nx   = state;
        grant_scan = 1'b0;
        grant_host = 1'b0;
        done       = 1'b0;
        expired    = 1'b0;
        den        = 1'b0;
        dwe        = 1'b0;
        daddr      = '0;
        di         = '0;
        unique case (state)
            IDLE: begin
                if (scan_want && (!host_want || last_grant == OWN_HOST)) begin
                    grant_scan = 1'b1;
                end else if (host_want) begin
                    grant_host = 1'b1;
                end
                if (grant_scan || grant_host) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                den = 1'b1;
                if (owner == OWN_HOST) begin
                    dwe   = host_we;
                    daddr = host_addr;
                    di    = host_wdata;
                end else begin
                    daddr = cur_addr;
                end
                state_nx = WAIT;
            end
            WAIT: begin
                if (drdy) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    expired  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state        <= IDLE;
            owner        <= OWN_SCAN;
            last_grant   <= OWN_HOST;
            ptr          <= '0;
            cur_slot     <= '0;
            cur_addr     <= '0;
            cnt          <= '0;
            scan_pending <= 1'b0;
            slot_data    <= '0;
            sample_valid <= 1'b0;
            sample_slot  <= '0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            sample_valid <= done && (owner == OWN_SCAN);
            host_ack     <= (done || expired) && (owner == OWN_HOST);
            cnt          <= (state == WAIT) ? cnt + CW'(1) : '0;

            // Slot choice and address are frozen here; config changes later do not touch this access.
            if (grant_scan) begin
                owner      <= OWN_SCAN;
                last_grant <= OWN_SCAN;
                cur_slot   <= pick_slot;
                cur_addr   <= slot_addr_cfg[pick_slot*DRP_AW +: DRP_AW];
            end
            if (grant_host) begin
                owner      <= OWN_HOST;
                last_grant <= OWN_HOST;
            end

            if (done && owner == OWN_SCAN) begin
                slot_data[cur_slot*DRP_DW +: DRP_DW] <= do_in;
                sample_slot                          <= cur_slot;
            end
            if (done && owner == OWN_HOST) begin
                host_rdata <= do_in;
            end
            if (expired && owner == OWN_HOST) begin
                host_rdata <= '0;
            end
            if (scan_end) begin
                ptr <= (cur_slot == SW'(NUM_SLOTS - 1)) ? '0 : cur_slot + SW'(1);
            end

            if (scan_req) begin
                scan_pending <= 1'b1;
            end else if (scan_end || (state == IDLE && scan_pending && !pick_found)) begin
                scan_pending <= 1'b0;
            end

            if (expired) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (scan_req && (scan_pending || (state != IDLE && owner == OWN_SCAN))) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule
